// File: rtl/caesar_decryption_pkg.sv
// Definitions shared by the per-algorithm decryption engines (Caesar, Scytale, ZigZag).
// Keeps the default widths and byte type identical across engines so the top level can mux them.
package caesar_decryption_pkg;

  localparam int D_WIDTH_DEF   = 8;
  localparam int KEY_WIDTH_DEF = 16;

  typedef logic [D_WIDTH_DEF-1:0] byte_t;

endpackage

// File: rtl/caesar_decryption.sv
// Streaming Caesar decryptor: data_o = data_i - key[D_WIDTH-1:0] (mod 2^D_WIDTH), registered.
// Latency 1 cycle, 1 byte/cycle, no backpressure; idle cycles drive data_o to zero.
module caesar_decryption
  import caesar_decryption_pkg::*;
#(
  parameter int D_WIDTH   = D_WIDTH_DEF,
  parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  logic [D_WIDTH-1:0] w_diff;
  logic [D_WIDTH-1:0] r_data;
  logic               r_valid;

  // Plain modular subtraction: every byte value is shifted, not just letters.
  assign w_diff = data_i - key[D_WIDTH-1:0];

  // Upper key bits exist only for bus compatibility with the other engines.
  generate
    if (KEY_WIDTH > D_WIDTH) begin : g_key_upper
      logic w_unused_key_upper;
      assign w_unused_key_upper = ^key[KEY_WIDTH-1:D_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (valid_i) begin
      r_data  <= w_diff;
      r_valid <= 1'b1;
    end else begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_caesar_decryption.sv
// Directed self-checking bench for caesar_decryption with immediate assertions at each check.
module tb_caesar_decryption;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [15:0] key;
  logic [7:0]  data_o;
  logic        valid_o;

  int tests  = 0;
  int failed = 0;

  caesar_decryption #(.D_WIDTH(8), .KEY_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key     (key),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d);
    check({tag, "_valid"}, {7'd0, valid_o}, {7'd0, v});
    check({tag, "_data"}, data_o, d);
  endtask

  initial begin
    logic [7:0] gap_din [5];
    logic       gap_vin [5];
    logic [7:0] gap_dexp [5];
    logic       gap_vexp [5];

    gap_din  = '{8'h10, 8'hAA, 8'h20, 8'h30, 8'hAA};
    gap_vin  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    gap_dexp = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h00};
    gap_vexp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held while a valid byte is driven
    rst_n   = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'h41;
    key     = 16'd3;
    #2;
    expect_out("rst_t0", 1'b0, 8'h00);
    step();
    expect_out("rst_c1", 1'b0, 8'h00);
    step();
    expect_out("rst_c2", 1'b0, 8'h00);

    rst_n   = 1'b1;
    valid_i = 1'b0;
    step();
    expect_out("idle", 1'b0, 8'h00);

    // Basic shift "DEF" -> "ABC"
    key = 16'd3; valid_i = 1'b1;
    data_i = 8'h44; step(); expect_out("shift_A", 1'b1, 8'h41);
    data_i = 8'h45; step(); expect_out("shift_B", 1'b1, 8'h42);
    data_i = 8'h46; step(); expect_out("shift_C", 1'b1, 8'h43);
    valid_i = 1'b0; data_i = 8'h99;
    step(); expect_out("shift_end", 1'b0, 8'h00);

    // Wrap-around and upper key byte ignored
    valid_i = 1'b1;
    key = 16'h0105; data_i = 8'h02; step(); expect_out("wrap", 1'b1, 8'hFD);
    key = 16'h0100; data_i = 8'h7A; step(); expect_out("key_0100", 1'b1, 8'h7A);
    key = 16'h0000; data_i = 8'hC3; step(); expect_out("key_zero", 1'b1, 8'hC3);

    // Gapped valid pattern
    key = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      valid_i = gap_vin[i];
      data_i  = gap_din[i];
      step();
      expect_out($sformatf("gap%0d", i), gap_vexp[i], gap_dexp[i]);
    end

    // Key changes between consecutive valid bytes
    valid_i = 1'b1; data_i = 8'h05;
    key = 16'd1; step(); expect_out("keychg1", 1'b1, 8'h04);
    key = 16'd2; step(); expect_out("keychg2", 1'b1, 8'h03);

    // Asynchronous reset mid-stream
    key = 16'd0; data_i = 8'h50;
    step(); expect_out("pre_rst", 1'b1, 8'h50);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_clr", 1'b0, 8'h00);
    data_i = 8'h77;
    step(); expect_out("rst_hold", 1'b0, 8'h00);
    #2;
    rst_n  = 1'b1;
    key    = 16'd1;
    data_i = 8'h66;
    #1;
    expect_out("post_rel", 1'b0, 8'h00);
    step(); expect_out("first_after", 1'b1, 8'h65);
    valid_i = 1'b0;
    step(); expect_out("final_idle", 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/caesar_decryption.md
# caesar_decryption

Streaming Caesar-cipher decryptor. Each valid input byte has the key subtracted from it, modulo 256, and the result is registered out one cycle later. The block is one of the per-algorithm engines behind the design's decryption top level, alongside the Scytale and ZigZag engines. It holds no message state and knows nothing about message boundaries or terminator bytes.

## Interface
Parameters:
- D_WIDTH, 8, data byte width.
- KEY_WIDTH, 16, key bus width (shared bus format with the other engines).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_i  input  D_WIDTH  encrypted byte.
- valid_i  input  1  data_i qualifier.
- key  input  KEY_WIDTH  shift amount.
  - Only key[D_WIDTH-1:0] is used.
  - Upper bits are ignored.
- data_o  output  D_WIDTH  decrypted byte.
- valid_o  output  1  data_o qualifier.

## Operation
- Decryption: data_o = (data_i − key[D_WIDTH-1:0]) mod 2^D_WIDTH.
  - Plain unsigned wrap-around subtraction.
  - No alphabet awareness: letters, digits and control bytes are all shifted alike.
- key is sampled in the same cycle as the byte it applies to. Key changes take effect on the next valid byte; no per-message latching.
- valid_i=1: register the result and set valid_o=1 on the next cycle.
- valid_i=0: valid_o=0 and data_o=0 on the next cycle. data_o is forced to zero rather than holding its last value.
- No backpressure: the block accepts a byte every cycle, with no ready signal and no buffering.
- Output register only; no FSM. The datapath is stateless apart from the output register.

## Timing
- Latency is exactly 1 cycle from a valid_i/data_i sample to valid_o/data_o.
- Throughput is 1 byte per cycle, sustained indefinitely.
- Reset asserted (rst_n=0), asynchronously:
  - data_o=0, valid_o=0 immediately.
  - Held there for as long as rst_n=0.
- Reset mid-stream: an in-flight byte is dropped, with no output after release.
- First byte after rst_n deasserts is treated normally; its output appears one cycle later.
- Back-to-back valid bytes give back-to-back valid outputs with no bubbles.
- Gaps in valid_i reproduce identically on valid_o, delayed by 1 cycle.
- Boundaries:
  - key low byte = 0: data_o = data_i.
  - data_i < key: wraps; e.g. 0x02 − 0x05 = 0xFD.
  - key = 0x0100: effective shift is 0 (upper byte ignored).
  - key changing on the same cycle as a valid byte: the new key value is used.

## Structure
- Shared package (common to all decryption engines):
  - D_WIDTH and KEY_WIDTH defaults.
  - Byte type.
- No sub-module; subtractor and output register live inline.
- Port list is identical in shape to the Scytale and ZigZag engines, so the top level can mux them uniformly.

## Test plan
- Reset:
  - Stimulus: rst_n=0 while driving valid_i=1, data_i=0x41, key=3.
  - Required: data_o=0 and valid_o=0 throughout; also assert rst_n asynchronously between clock edges and check the outputs clear immediately.
- Basic shift:
  - Stimulus: key=3, stream "DEF" (0x44, 0x45, 0x46) on consecutive cycles.
  - Required: valid_o high for 3 consecutive cycles starting one cycle later, carrying 0x41, 0x42, 0x43 ("ABC").
- Wrap-around and upper-key ignore:
  - Stimulus: key=0x0105, data_i=0x02.
  - Required: data_o=0xFD after 1 cycle.
  - Stimulus: key=0x0100, data_i=0x7A.
  - Required: data_o=0x7A.
- Gapped valid:
  - Stimulus: valid_i pattern 1,0,1,1,0 with data 0x10, x, 0x20, 0x30, x and key=0x10.
  - Required: valid_o pattern 1,0,1,1,0 one cycle later, data 0x00, 0, 0x10, 0x20, 0.
- Mid-stream key change and reset:
  - Stimulus: key switches 1→2 between consecutive valid bytes 0x05, 0x05.
  - Required: outputs 0x04, 0x03.
  - Stimulus: pulse rst_n low mid-stream.
  - Required: outputs clear immediately; the first post-reset byte emerges 1 cycle after it is presented.
